// File: rtl/sd_seq_defs_pkg.sv
// rtl/sd_seq_defs_pkg.sv - shared widths and state encodings for the tone sequencer
package sd_seq_defs;

    localparam int SD_KW        = 28;
    localparam int SD_DEPTH     = 8;
    localparam int SD_AW        = 3;
    localparam int SD_DWELL_W   = 16;
    localparam int SD_PRIME_CYC = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/sd_seq_table.sv
// rtl/sd_seq_table.sv - tuning-word/dwell register file, one write port, async-read
module sd_seq_table
    import sd_seq_defs::*;
#(
    parameter int KW      = SD_KW,
    parameter int DWELL_W = SD_DWELL_W,
    parameter int DEPTH   = SD_DEPTH,
    parameter int AW      = SD_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [KW-1:0]      wkin_i,
    input  logic [DWELL_W-1:0] wdwell_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [KW-1:0]      rkin_o,
    output logic [DWELL_W-1:0] rdwell_o
);

    logic [KW-1:0]      kin_q   [DEPTH];
    logic [DWELL_W-1:0] dwell_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                kin_q[i]   <= '0;
                dwell_q[i] <= '0;
            end
        end else if (we_i) begin
            kin_q[waddr_i]   <= wkin_i;
            dwell_q[waddr_i] <= wdwell_i;
        end
    end

    assign rkin_o   = kin_q[raddr_i];
    assign rdwell_o = dwell_q[raddr_i];

endmodule

// File: rtl/sd_tone_sequencer.sv
// rtl/sd_tone_sequencer.sv - primes the sigma-delta modulator then steps kin through the table
module sd_tone_sequencer
    import sd_seq_defs::*;
#(
    parameter int KW        = SD_KW,
    parameter int DEPTH     = SD_DEPTH,
    parameter int AW        = SD_AW,
    parameter int DWELL_W   = SD_DWELL_W,
    parameter int PRIME_CYC = SD_PRIME_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [KW-1:0]      cfg_kin,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW-1:0]      cfg_last,
    input  logic               cfg_loop,
    input  logic               start,
    input  logic               stop,
    output logic [KW-1:0]      kin_out,
    output logic               sd_reset,
    output logic               busy,
    output logic               done,
    output logic               step_strobe,
    output logic [AW-1:0]      step_idx,
    output logic               cfg_err
);

    localparam int PW = $clog2(PRIME_CYC + 1);

    logic [1:0]         state_q, state_d;
    logic [KW-1:0]      kin_q, kin_d;
    logic               sdr_q, sdr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               strobe_q, strobe_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               err_q, err_d;
    logic [PW-1:0]      prime_q, prime_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [AW-1:0]      last_q, last_d;
    logic               loop_q, loop_d;

    logic               tbl_we;
    logic [AW-1:0]      rd_idx;
    logic [KW-1:0]      rd_kin;
    logic [DWELL_W-1:0] rd_dwell;

    assign tbl_we = cfg_we && (state_q == ST_IDLE);

    // The only entry ever fetched is the next one to show: 0 when starting or wrapping.
    assign rd_idx = (state_q == ST_RUN && idx_q != last_q) ? idx_q + AW'(1) : '0;

    sd_seq_table #(
        .KW      (KW),
        .DWELL_W (DWELL_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .we_i     (tbl_we),
        .waddr_i  (cfg_addr),
        .wkin_i   (cfg_kin),
        .wdwell_i (cfg_dwell),
        .raddr_i  (rd_idx),
        .rkin_o   (rd_kin),
        .rdwell_o (rd_dwell)
    );

    always_comb begin
        state_d  = state_q;
        kin_d    = kin_q;
        sdr_d    = sdr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        strobe_d = 1'b0;
        idx_d    = idx_q;
        err_d    = cfg_we && (state_q != ST_IDLE);
        prime_d  = prime_q;
        dwell_d  = dwell_q;
        last_d   = last_q;
        loop_d   = loop_q;

        case (state_q)
            ST_IDLE: begin
                kin_d  = '0;
                sdr_d  = 1'b1;
                busy_d = 1'b0;
                idx_d  = '0;
                if (!stop && start) begin
                    state_d = ST_PRIME;
                    last_d  = cfg_last;
                    loop_d  = cfg_loop;
                    kin_d   = rd_kin;
                    busy_d  = 1'b1;
                    prime_d = PW'(PRIME_CYC - 1);
                end
            end
            ST_PRIME: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    kin_d   = '0;
                    sdr_d   = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else if (prime_q == '0) begin
                    state_d  = ST_RUN;
                    sdr_d    = 1'b0;
                    dwell_d  = rd_dwell;
                    strobe_d = 1'b1;
                end else begin
                    prime_d = prime_q - PW'(1);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    kin_d   = '0;
                    sdr_d   = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (idx_q != last_q || loop_q) begin
                    idx_d    = rd_idx;
                    kin_d    = rd_kin;
                    dwell_d  = rd_dwell;
                    strobe_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    kin_d   = '0;
                    sdr_d   = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                kin_d   = '0;
                sdr_d   = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            kin_q    <= '0;
            sdr_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            prime_q  <= '0;
            dwell_q  <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kin_q    <= kin_d;
            sdr_q    <= sdr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            prime_q  <= prime_d;
            dwell_q  <= dwell_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
        end
    end

    assign kin_out     = kin_q;
    assign sd_reset    = sdr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_strobe = strobe_q;
    assign step_idx    = idx_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_sd_tone_sequencer.sv
// tb/tb_sd_tone_sequencer.sv - directed self-checking bench for sd_tone_sequencer
module tb_sd_tone_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [27:0] cfg_kin;
    logic [15:0] cfg_dwell;
    logic [2:0]  cfg_last;
    logic        cfg_loop;
    logic        start;
    logic        stop;
    logic [27:0] kin_out;
    logic        sd_reset;
    logic        busy;
    logic        done;
    logic        step_strobe;
    logic [2:0]  step_idx;
    logic        cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    sd_tone_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_kin     (cfg_kin),
        .cfg_dwell   (cfg_dwell),
        .cfg_last    (cfg_last),
        .cfg_loop    (cfg_loop),
        .start       (start),
        .stop        (stop),
        .kin_out     (kin_out),
        .sd_reset    (sd_reset),
        .busy        (busy),
        .done        (done),
        .step_strobe (step_strobe),
        .step_idx    (step_idx),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [27:0] k, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_kin   = k;
        cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
        check($sformatf("wr%0d_cfg_err", a), {31'd0, cfg_err}, 32'd0);
    endtask

    task automatic expect_idle(input string tag, input logic exp_done);
        check({tag, "_kin"},   {4'd0, kin_out}, 32'd0);
        check({tag, "_sdr"},   {31'd0, sd_reset}, 32'd1);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_idx"},   {29'd0, step_idx}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, {31'd0, exp_done});
    endtask

    task automatic expect_prime(input string tag, input logic [27:0] k0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_p%0d_sdr", tag, i), {31'd0, sd_reset}, 32'd1);
            check($sformatf("%s_p%0d_kin", tag, i), {4'd0, kin_out}, {4'd0, k0});
            check($sformatf("%s_p%0d_busy", tag, i), {31'd0, busy}, 32'd1);
            check($sformatf("%s_p%0d_stb", tag, i), {31'd0, step_strobe}, 32'd0);
            tick();
        end
    endtask

    // poke drives start plus a blocked table write on the first cycle of the entry
    task automatic expect_entry(input string tag, input logic [27:0] k, input logic [2:0] idx,
                                input int n, input bit poke);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_c%0d_kin", tag, i), {4'd0, kin_out}, {4'd0, k});
            check($sformatf("%s_c%0d_idx", tag, i), {29'd0, step_idx}, {29'd0, idx});
            check($sformatf("%s_c%0d_sdr", tag, i), {31'd0, sd_reset}, 32'd0);
            check($sformatf("%s_c%0d_busy", tag, i), {31'd0, busy}, 32'd1);
            check($sformatf("%s_c%0d_stb", tag, i), {31'd0, step_strobe}, {31'd0, i == 0});
            check($sformatf("%s_c%0d_done", tag, i), {31'd0, done}, 32'd0);
            if (poke && i == 0) begin
                start     = 1'b1;
                cfg_we    = 1'b1;
                cfg_addr  = 3'd1;
                cfg_kin   = 28'hABC;
                cfg_dwell = 16'd7;
            end
            tick();
            if (poke && i == 0) begin
                start  = 1'b0;
                cfg_we = 1'b0;
                check({tag, "_cfg_err_pulse"}, {31'd0, cfg_err}, 32'd1);
            end
            if (poke && i == 1) check({tag, "_cfg_err_clear"}, {31'd0, cfg_err}, 32'd0);
        end
    endtask

    task automatic kick(input logic [2:0] last, input logic loop_en);
        cfg_last = last;
        cfg_loop = loop_en;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_kin = '0; cfg_dwell = '0;
        cfg_last = '0; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0;
        tick(); tick();
        expect_idle("in_reset", 1'b0);
        check("in_reset_stb", {31'd0, step_strobe}, 32'd0);
        check("in_reset_err", {31'd0, cfg_err}, 32'd0);
        reset = 1'b1;
        tick();
        expect_idle("post_reset", 1'b0);

        write_entry(3'd0, 28'h100, 16'd2);
        write_entry(3'd1, 28'h200, 16'd0);
        write_entry(3'd2, 28'h300, 16'd5);

        // one-shot
        kick(3'd2, 1'b0);
        expect_prime("os", 28'h100);
        expect_entry("os_e0", 28'h100, 3'd0, 3, 1'b0);
        expect_entry("os_e1", 28'h200, 3'd1, 1, 1'b0);
        expect_entry("os_e2", 28'h300, 3'd2, 6, 1'b0);
        expect_idle("os_done", 1'b1);
        tick();
        expect_idle("os_after", 1'b0);

        // looped, wraps without re-prime, then stop during entry 1
        kick(3'd2, 1'b1);
        expect_prime("lp", 28'h100);
        expect_entry("lp_e0", 28'h100, 3'd0, 3, 1'b0);
        expect_entry("lp_e1", 28'h200, 3'd1, 1, 1'b0);
        expect_entry("lp_e2", 28'h300, 3'd2, 6, 1'b0);
        expect_entry("lp_w0", 28'h100, 3'd0, 3, 1'b0);
        check("lp_w1_kin", {4'd0, kin_out}, 32'h200);
        check("lp_w1_stb", {31'd0, step_strobe}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_idle("lp_stop", 1'b0);
        tick();
        expect_idle("lp_stop2", 1'b0);

        // start with stop in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        expect_idle("ss_idle", 1'b0);
        tick();
        expect_idle("ss_idle2", 1'b0);

        // start and a table write while running: no timing change, write dropped
        kick(3'd2, 1'b0);
        expect_prime("bz", 28'h100);
        expect_entry("bz_e0", 28'h100, 3'd0, 3, 1'b1);
        expect_entry("bz_e1", 28'h200, 3'd1, 1, 1'b0);
        expect_entry("bz_e2", 28'h300, 3'd2, 6, 1'b0);
        expect_idle("bz_done", 1'b1);
        tick();

        // async reset in the middle of entry 2
        kick(3'd2, 1'b0);
        expect_prime("ar", 28'h100);
        expect_entry("ar_e0", 28'h100, 3'd0, 3, 1'b0);
        expect_entry("ar_e1", 28'h200, 3'd1, 1, 1'b0);
        tick(); tick();
        check("ar_pre_kin", {4'd0, kin_out}, 32'h300);
        reset = 1'b0;
        #1;
        expect_idle("ar_async", 1'b0);
        check("ar_async_stb", {31'd0, step_strobe}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // table is cleared: single entry of kin 0 lasting one cycle
        kick(3'd0, 1'b0);
        expect_prime("cl", 28'h0);
        expect_entry("cl_e0", 28'h0, 3'd0, 1, 1'b0);
        expect_idle("cl_done", 1'b1);
        tick();
        expect_idle("cl_after", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
